// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - picks the display source each ms and drives three 7-segment digits
//
// Purpose: shares the 3-digit display between temperature, setpoint and alarm.
// Once per millisecond tick the highest-priority source is snapshotted and
// converted to BCD by a sequential double-dabble engine. The BCD digits are then
// encoded into active-low gfedcba segment codes.
//
// Ports:
//   clk100mhz   system clock
//   rst         asynchronous active-high reset
//   temp_val    measured temperature (binary), captured when temp_valid=1
//   setp_val    setpoint (binary), captured when setp_wr=1
//   alarm       alarm level; shows temperature, blinking
//   unidades7 / decenas7 / centenas7  digit segments, active low
//   src         shown source: 0 temp, 1 setpoint, 2 alarm, 3 no data
//   upd         one-cycle pulse when a new digit set is registered
module display_source_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int HOLD_MS  = 3000,
  parameter int BLINK_MS = 500
) (
  input  logic       clk100mhz,
  input  logic       rst,
  input  logic [9:0] temp_val,
  input  logic       temp_valid,
  input  logic [9:0] setp_val,
  input  logic       setp_wr,
  input  logic       alarm,
  output logic [6:0] unidades7,
  output logic [6:0] decenas7,
  output logic [6:0] centenas7,
  output logic [1:0] src,
  output logic       upd
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int HOLD_W  = $clog2(HOLD_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_MS + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_ENCODE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // ---------------- millisecond tick ----------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- input capture ----------------
  logic [9:0] temp_q;
  logic [9:0] setp_q;
  logic       temp_seen;

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      temp_q    <= '0;
      setp_q    <= '0;
      temp_seen <= 1'b0;
    end else begin
      if (temp_valid) begin
        temp_q    <= temp_val;
        temp_seen <= 1'b1;
      end
      if (setp_wr) setp_q <= setp_val;
    end
  end

  // ---------------- setpoint hold timer ----------------
  // A write always reloads, even on a tick cycle, so a write can never be lost
  // to a coincident decrement.
  logic [HOLD_W-1:0] hold_q;

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst)                        hold_q <= '0;
    else if (setp_wr)               hold_q <= HOLD_W'(HOLD_MS);
    else if (tick && hold_q != '0)  hold_q <= hold_q - 1'b1;
  end

  // ---------------- alarm blink ----------------
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!alarm) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- conversion FSM ----------------
  state_t      state_q, state_d;
  logic [3:0]  shift_cnt;
  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [1:0]  src_snap;
  logic        dash_q;
  logic        blank_q;

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick) state_d = S_LOAD;
      S_LOAD:   state_d = S_SHIFT;
      S_SHIFT:  if (shift_cnt == 4'd1) state_d = S_ENCODE;
      S_ENCODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Source selection, evaluated combinationally and captured in LOAD.
  logic [1:0] load_src;
  logic [9:0] load_val;
  logic       load_dash;
  logic       load_blank;

  always_comb begin
    load_src   = 2'd3;
    load_val   = '0;
    load_dash  = 1'b1;
    load_blank = 1'b0;
    if (alarm) begin
      load_src   = 2'd2;
      load_val   = temp_q;
      load_dash  = ~temp_seen;
      load_blank = ~blink_on;
    end else if (hold_q != '0) begin
      load_src  = 2'd1;
      load_val  = setp_q;
      load_dash = 1'b0;
    end else if (temp_seen) begin
      load_src  = 2'd0;
      load_val  = temp_q;
      load_dash = 1'b0;
    end
  end

  logic [11:0] bcd_adj;
  assign bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      shift_cnt <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      src_snap  <= 2'd3;
      dash_q    <= 1'b1;
      blank_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          src_snap  <= load_src;
          dash_q    <= load_dash;
          blank_q   <= load_blank;
          bin_q     <= (load_val > 10'd999) ? 10'd999 : load_val;
          bcd_q     <= '0;
          shift_cnt <= 4'd10;
        end
        S_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
          shift_cnt      <= shift_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- output encode ----------------
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      unidades7 <= SEG_BLANK;
      decenas7  <= SEG_BLANK;
      centenas7 <= SEG_BLANK;
      src       <= 2'd3;
      upd       <= 1'b0;
    end else begin
      upd <= (state_q == S_ENCODE);
      if (state_q == S_ENCODE) begin
        src <= src_snap;
        if (blank_q) begin
          unidades7 <= SEG_BLANK;
          decenas7  <= SEG_BLANK;
          centenas7 <= SEG_BLANK;
        end else if (dash_q) begin
          unidades7 <= SEG_DASH;
          decenas7  <= SEG_DASH;
          centenas7 <= SEG_DASH;
        end else begin
          // Leading-zero blanking: units always lit.
          unidades7 <= seg7(bcd_q[3:0]);
          decenas7  <= (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
          centenas7 <= (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
        end
      end
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// tb/tb_display_source_scheduler.sv - directed bench for display_source_scheduler
module tb_display_source_scheduler;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;

  logic       clk100mhz = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] temp_val = '0;
  logic       temp_valid = 1'b0;
  logic [9:0] setp_val = '0;
  logic       setp_wr = 1'b0;
  logic       alarm = 1'b0;
  logic [6:0] unidades7, decenas7, centenas7;
  logic [1:0] src;
  logic       upd;

  int checks = 0;
  int errors = 0;

  display_source_scheduler #(.TICK_DIV(20), .HOLD_MS(5), .BLINK_MS(2)) dut (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .temp_val  (temp_val),
    .temp_valid(temp_valid),
    .setp_val  (setp_val),
    .setp_wr   (setp_wr),
    .alarm     (alarm),
    .unidades7 (unidades7),
    .decenas7  (decenas7),
    .centenas7 (centenas7),
    .src       (src),
    .upd       (upd)
  );

  always #5 clk100mhz = ~clk100mhz;

  typedef struct {
    logic       tv;
    logic [9:0] temp;
    logic       sw;
    logic [9:0] setp;
    logic       al;
    logic [1:0] e_src;
    logic [6:0] e_h;
    logic [6:0] e_t;
    logic [6:0] e_u;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_upd(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk100mhz);
      n++;
      if (upd) break;
    end
    checks++;
    if (upd !== 1'b1) begin
      errors++;
      $display("FAIL upd_timeout: got no upd within %0d cycles expected one", n);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [1:0] e_src,
                          input logic [6:0] e_h, input logic [6:0] e_t, input logic [6:0] e_u);
    chk({tag, " src"}, 16'(src), 16'(e_src));
    chk({tag, " centenas"}, 16'(centenas7), 16'(e_h));
    chk({tag, " decenas"}, 16'(decenas7), 16'(e_t));
    chk({tag, " unidades"}, 16'(unidades7), 16'(e_u));
  endtask

  task automatic pulse_setp(input logic [9:0] v);
    setp_val = v;
    setp_wr  = 1'b1;
    @(negedge clk100mhz);
    setp_wr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_upd;

    //         tv    temp     sw    setp     al    src   h   t   u
    vecs[0]  = '{1'b1, 10'd7,    1'b0, 10'd0,   1'b0, 2'd0, BL, BL, S7};
    vecs[1]  = '{1'b1, 10'd1023, 1'b0, 10'd0,   1'b0, 2'd0, S9, S9, S9};
    vecs[2]  = '{1'b1, 10'd25,   1'b0, 10'd0,   1'b0, 2'd0, BL, S2, S5};
    vecs[3]  = '{1'b0, 10'd0,    1'b1, 10'd180, 1'b0, 2'd1, S1, S8, S0};
    vecs[4]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd1, S1, S8, S0};
    vecs[5]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd1, S1, S8, S0};
    vecs[6]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd1, S1, S8, S0};
    vecs[7]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd0, BL, S2, S5};
    vecs[8]  = '{1'b1, 10'd42,   1'b0, 10'd0,   1'b1, 2'd2, BL, S4, S2};
    vecs[9]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b1, 2'd2, BL, BL, BL};
    vecs[10] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b1, 2'd2, BL, BL, BL};
    vecs[11] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b1, 2'd2, BL, S4, S2};
    vecs[12] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b1, 2'd2, BL, S4, S2};
    vecs[13] = '{1'b0, 10'd0,    1'b1, 10'd305, 1'b1, 2'd2, BL, BL, BL};
    vecs[14] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd1, S3, S0, S5};
    vecs[15] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd1, S3, S0, S5};
    vecs[16] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd1, S3, S0, S5};
    vecs[17] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 2'd0, BL, S4, S2};

    // Reset state
    repeat (3) @(negedge clk100mhz);
    chk_disp("reset", 2'd3, BL, BL, BL);
    chk("reset upd", 16'(upd), 16'd0);

    // First update after release: no data -> dashes, tick+13 latency
    rst = 1'b0;
    wait_upd(n);
    chk("first upd latency", 16'(n), 16'd32);
    chk_disp("nodata", 2'd3, DA, DA, DA);
    @(negedge clk100mhz);
    chk("upd one cycle", 16'(upd), 16'd0);

    // Table-driven vectors, each applied right after an update
    for (int i = 0; i < 18; i++) begin
      alarm      = vecs[i].al;
      temp_val   = vecs[i].temp;
      setp_val   = vecs[i].setp;
      temp_valid = vecs[i].tv;
      setp_wr    = vecs[i].sw;
      @(negedge clk100mhz);
      temp_valid = 1'b0;
      setp_wr    = 1'b0;
      wait_upd(n);
      chk_disp($sformatf("v%0d", i), vecs[i].e_src, vecs[i].e_h, vecs[i].e_t, vecs[i].e_u);
    end

    // Setpoint write coincident with a tick while the hold timer is at 1
    pulse_setp(10'd123);
    for (int k = 0; k < 4; k++) begin
      wait_upd(n);
      chk_disp($sformatf("hold123_%0d", k), 2'd1, S1, S2, S3);
    end
    repeat (7) @(negedge clk100mhz);
    pulse_setp(10'd456);
    wait_upd(n);
    chk("coincident latency", 16'(n), 16'd12);
    chk_disp("reload0", 2'd1, S4, S5, S6);
    for (int k = 1; k < 5; k++) begin
      wait_upd(n);
      chk_disp($sformatf("reload%0d", k), 2'd1, S4, S5, S6);
    end
    wait_upd(n);
    chk_disp("hold expired", 2'd0, BL, S4, S2);

    // Reset asserted during SHIFT
    repeat (10) @(negedge clk100mhz);
    rst = 1'b1;
    #1;
    chk_disp("midreset", 2'd3, BL, BL, BL);
    chk("midreset upd", 16'(upd), 16'd0);
    saw_upd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk100mhz);
      if (upd) saw_upd = 1'b1;
    end
    chk("no upd in reset", 16'(saw_upd), 16'd0);
    alarm = 1'b1;
    rst   = 1'b0;
    wait_upd(n);
    chk("post-reset latency", 16'(n), 16'd32);
    chk_disp("alarm no temp", 2'd2, DA, DA, DA);
    alarm = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Shares the 3-digit seven-segment display of the refrigeration controller among three sources: measured temperature, setpoint and alarm.
- Each millisecond it picks the highest-priority source and converts the binary value to BCD with a sequential double-dabble engine.
- It encodes the digits as active-low segment codes and drives the unidades7/decenas7/centenas7 inputs of the display multiplexer.

Parameters:
TICK_DIV, 100000, clk100mhz cycles per 1 ms tick
HOLD_MS, 3000, ms the setpoint stays on display after a write
BLINK_MS, 500, ms per alarm blink half-period

Ports:
clk100mhz  input  1  system clock, 100 MHz
rst  input  1  asynchronous active-high reset
temp_val  input  10  measured temperature, binary
temp_valid  input  1  capture temp_val this cycle
setp_val  input  10  setpoint, binary
setp_wr  input  1  one-cycle pulse: setpoint changed
alarm  input  1  alarm level
unidades7  output  7  units digit segments, active low, gfedcba
decenas7  output  7  tens digit segments
centenas7  output  7  hundreds digit segments
src  output  2  shown source: 0 temperature, 1 setpoint, 2 alarm, 3 no data
upd  output  1  one-cycle pulse when digit outputs change value set

Behaviour:
- Clock and reset: one clock domain; rst is asynchronous and active-high.
- Reset values: all digits 1111111 (blank); src=3; upd=0; tick counter 0; hold timer 0; blink phase ON; temp_seen=0; conversion FSM IDLE.
- Tick generation:
  - The counter counts 0..TICK_DIV-1.
  - tick is high for one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
- Input capture:
  - temp_valid=1 registers temp_val and sets temp_seen.
  - setp_wr=1 registers setp_val and reloads the hold timer to HOLD_MS, even while an alarm is active.
- Hold timer: decrements by 1 on each tick while nonzero. If setp_wr and tick coincide, the reload wins.
- Blink:
  - The blink counter counts ticks only while alarm=1 and toggles the phase every BLINK_MS ticks.
  - When alarm=0, the counter clears and the phase is forced ON.
- Source priority, sampled in LOAD:
  - alarm=1 → 2
  - else hold timer ≠0 → 1
  - else temp_seen → 0
  - else → 3
  - Alarm displays the temperature value; with temp_seen=0 it displays "---".
- Conversion FSM, states IDLE, LOAD, SHIFT, ENCODE:
  - IDLE→LOAD on tick.
  - LOAD: snapshot the source and value. Values >999 saturate to 999. Clear the BCD register and set the shift count to 10.
  - SHIFT: one double-dabble step per cycle (add 3 to any BCD nibble ≥5, then shift left one bit). Exit after 10 cycles.
  - ENCODE: map the BCD digits to segment codes, register the outputs, pulse upd; next state IDLE.
- Latency: tick in cycle T → LOAD T+1, SHIFT T+2..T+11, ENCODE T+12, outputs and upd visible T+13.
- Data visibility: setp_wr or temp_valid in cycle T is visible to the LOAD in T+1.
- Tick handling: a tick arriving while the FSM is not in IDLE is ignored. Never true when TICK_DIV≥14; TICK_DIV<14 is illegal.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0. Units are never blanked.
- src=3 output: all three digits show dash.
- Alarm OFF phase: all digits blank, src=2.
- Reset mid-conversion: immediate return to reset values. No upd is generated for the aborted conversion.

Test Plan:
Bench parameters: TICK_DIV=20, HOLD_MS=5, BLINK_MS=2.
- Release reset with no inputs → after the first tick+13 cycles: all digits dash, src=3, upd pulses once.
- temp_val=7, temp_valid pulse → unidades7=1111000, decenas7=centenas7=1111111, src=0. Then temp_val=1023 → 999: all three digits 0010000.
- temp=25 shown, setp_wr with setp_val=180 → next update src=1, digits 1/8/0 = 1111001/0000000/1000000.
  - src=1 is held for 5 ticks, then src=0 with digits blank/2/5.
- setp_wr coincident with tick, while the hold timer is at 1 → timer reloads to 5, not 0. The setpoint stays for 5 more ticks.
- alarm=1 with temp=42 → src=2; digits alternate blank/4/2 and all blank every 2 ticks.
  - alarm=0 → phase ON immediately; src returns to 1 or 0 by priority.
- Assert rst during SHIFT → outputs blank and src=3 immediately; no upd pulse. Normal operation resumes after release.
